// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle between ID, the later pipeline stages and the ID/EX register.
//   master : ID/EX-MEM/MEM-WB side; drives stall/flush, id_* and forwarding
//            inputs, observes the EX outputs and load_use.
//   slave  : id_ex_stage itself.
// ----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int XLEN = 64
);
    // ID -> EX
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_alu_src;
    logic [1:0]      id_alu_op;
    logic [2:0]      id_funct3;
    logic            id_funct7_30;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_mem_to_reg;
    logic            id_branch;
    // Later stages (forwarding sources)
    logic [4:0]      exmem_rd;
    logic [4:0]      memwb_rd;
    logic            exmem_reg_write;
    logic            memwb_reg_write;
    logic [XLEN-1:0] exmem_result;
    logic [XLEN-1:0] memwb_result;
    // EX outputs
    logic            ex_valid;
    logic [XLEN-1:0] alu_data1;
    logic [XLEN-1:0] alu_data2;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] ex_store_data;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_branch;
    logic            load_use;

    modport master (
        output stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_src, id_alu_op, id_funct3,
               id_funct7_30, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_branch, exmem_rd, memwb_rd,
               exmem_reg_write, memwb_reg_write, exmem_result, memwb_result,
        input  ex_valid, alu_data1, alu_data2, alu_ctrl, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_branch, load_use
    );

    modport slave (
        input  stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_src, id_alu_op, id_funct3,
               id_funct7_30, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_branch, exmem_rd, memwb_rd,
               exmem_reg_write, memwb_reg_write, exmem_result, memwb_result,
        output ex_valid, alu_data1, alu_data2, alu_ctrl, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_branch, load_use
    );
endinterface

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus the execute-operand front end feeding the ALU:
// forwarding muxes, operand routing, ALU control decode and load-use detect.
//   i_clk   : rising-edge clock
//   i_reset : synchronous active-high reset, clears every register
//   bus     : id_ex_stage_if.slave (ID inputs, forwarding inputs, EX outputs)
// Build option: define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB
// forwarding; without it the operands are always the registered regfile data.
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic         i_clk,
    input  logic         i_reset,
    id_ex_stage_if.slave bus
);
    logic            r_valid;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_alu_src;
    logic [1:0]      r_alu_op;
    logic [2:0]      r_funct3;
    logic            r_funct7_30;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_mem_to_reg;
    logic            r_branch;

    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;
    logic [3:0]      w_alu_ctrl;

    // Flush only kills validity and control; data fields are don't-care
    // in a bubble, so they are left alone.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid      <= 1'b0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= '0;
            r_funct3     <= '0;
            r_funct7_30  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
        end else if (bus.flush) begin
            r_valid      <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
        end else if (!bus.stall) begin
            r_valid      <= bus.id_valid;
            r_rs1_data   <= bus.id_rs1_data;
            r_rs2_data   <= bus.id_rs2_data;
            r_imm        <= bus.id_imm;
            r_rs1        <= bus.id_rs1;
            r_rs2        <= bus.id_rs2;
            r_rd         <= bus.id_rd;
            r_alu_src    <= bus.id_alu_src;
            r_alu_op     <= bus.id_alu_op;
            r_funct3     <= bus.id_funct3;
            r_funct7_30  <= bus.id_funct7_30;
            r_reg_write  <= bus.id_reg_write;
            r_mem_read   <= bus.id_mem_read;
            r_mem_write  <= bus.id_mem_write;
            r_mem_to_reg <= bus.id_mem_to_reg;
            r_branch     <= bus.id_branch;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // EX/MEM is the younger result, so it is checked first. x0 never forwards.
    always_comb begin
        w_fwd1 = r_rs1_data;
        if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == r_rs1)
            w_fwd1 = bus.exmem_result;
        else if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == r_rs1)
            w_fwd1 = bus.memwb_result;
    end

    always_comb begin
        w_fwd2 = r_rs2_data;
        if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == r_rs2)
            w_fwd2 = bus.exmem_result;
        else if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == r_rs2)
            w_fwd2 = bus.memwb_result;
    end
`else
    assign w_fwd1 = r_rs1_data;
    assign w_fwd2 = r_rs2_data;

    // Forwarding inputs and source indices have no consumer in this build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{bus.exmem_rd, bus.memwb_rd, bus.exmem_reg_write,
                            bus.memwb_reg_write, bus.exmem_result,
                            bus.memwb_result, r_rs1, r_rs2};
`endif

    // 1111 is an intentionally unsupported code; the ALU returns 0 for it.
    always_comb begin
        w_alu_ctrl = 4'b0000;
        if (r_valid) begin
            case (r_alu_op)
                2'b00: w_alu_ctrl = 4'b0010;
                2'b01: w_alu_ctrl = 4'b0110;
                2'b10: begin
                    case (r_funct3)
                        3'b000:  w_alu_ctrl = r_funct7_30 ? 4'b0110 : 4'b0010;
                        3'b111:  w_alu_ctrl = 4'b0000;
                        3'b110:  w_alu_ctrl = 4'b0001;
                        default: w_alu_ctrl = 4'b1111;
                    endcase
                end
                default: begin
                    case (r_funct3)
                        3'b000:  w_alu_ctrl = 4'b0010;
                        3'b111:  w_alu_ctrl = 4'b0000;
                        3'b110:  w_alu_ctrl = 4'b0001;
                        default: w_alu_ctrl = 4'b1111;
                    endcase
                end
            endcase
        end
    end

    assign bus.ex_valid      = r_valid;
    assign bus.alu_data1     = w_fwd1;
    assign bus.alu_data2     = r_alu_src ? r_imm : w_fwd2;
    assign bus.alu_ctrl      = w_alu_ctrl;
    assign bus.ex_store_data = w_fwd2;
    assign bus.ex_rd         = r_rd;

    // Stale control bits may survive in a bubble; gate them with validity.
    assign bus.ex_reg_write  = r_valid & r_reg_write;
    assign bus.ex_mem_read   = r_valid & r_mem_read;
    assign bus.ex_mem_write  = r_valid & r_mem_write;
    assign bus.ex_mem_to_reg = r_valid & r_mem_to_reg;
    assign bus.ex_branch     = r_valid & r_branch;

    // The loaded value is not available until MEM ends, so a dependent
    // instruction in ID must wait one cycle. ID owns the stall/flush response.
    assign bus.load_use = r_valid && r_mem_read && (r_rd != 5'd0) &&
                          ((r_rd == bus.id_rs1) || (r_rd == bus.id_rs2));
endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed vectors for id_ex_stage. Stimulus pushes the expected EX outputs
// into a queue; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;
    localparam bit FWD =
`ifdef ID_EX_FORWARDING_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic        care;   // compare data fields (operands, store data, rd)
        logic        v;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [3:0]  c;
        logic [63:0] st;
        logic [4:0]  rd;
        logic [4:0]  c5;     // {reg_write, mem_read, mem_write, mem_to_reg, branch}
        logic        lu;
    } exp_t;

    logic clk;
    logic reset;
    id_ex_stage_if #(.XLEN(64)) bus ();

    id_ex_stage #(.XLEN(64)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [1:0] t_op  [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01};
    logic [2:0] t_f3  [9] = '{3'b000, 3'b111, 3'b110, 3'b001, 3'b000, 3'b111, 3'b100, 3'b101, 3'b010};
    logic       t_f7  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] t_exp [9] = '{4'b0010, 4'b0000, 4'b0001, 4'b1111, 4'b0010, 4'b0000, 4'b1111, 4'b0010, 4'b0110};

    // Monitor: compares every expectation queued since the last falling edge.
    exp_t       m_e;
    string      m_nm;
    logic       m_bad;
    logic [4:0] m_c5;
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            m_e  = exp_q.pop_front();
            m_nm = name_q.pop_front();
            checks++;
            m_c5 = {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                    bus.ex_mem_to_reg, bus.ex_branch};
            m_bad = (bus.ex_valid !== m_e.v) || (bus.alu_ctrl !== m_e.c) ||
                    (m_c5 !== m_e.c5) || (bus.load_use !== m_e.lu);
            if (m_e.care)
                m_bad = m_bad || (bus.alu_data1 !== m_e.d1) || (bus.alu_data2 !== m_e.d2) ||
                        (bus.ex_store_data !== m_e.st) || (bus.ex_rd !== m_e.rd);
            if (m_bad) begin
                errors++;
                $display("FAIL %s: got v=%0b d1=%h d2=%h ctrl=%b st=%h rd=%0d c5=%b lu=%0b, want v=%0b d1=%h d2=%h ctrl=%b st=%h rd=%0d c5=%b lu=%0b (data checked=%0b)",
                         m_nm, bus.ex_valid, bus.alu_data1, bus.alu_data2, bus.alu_ctrl,
                         bus.ex_store_data, bus.ex_rd, m_c5, bus.load_use,
                         m_e.v, m_e.d1, m_e.d2, m_e.c, m_e.st, m_e.rd, m_e.c5, m_e.lu, m_e.care);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [63:0] d1, input logic [63:0] d2,
                            input logic [63:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic src, input logic [1:0] op,
                            input logic [2:0] f3, input logic f7, input logic [4:0] c5);
        bus.id_valid     = v;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_alu_src   = src;
        bus.id_alu_op    = op;
        bus.id_funct3    = f3;
        bus.id_funct7_30 = f7;
        {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
         bus.id_mem_to_reg, bus.id_branch} = c5;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [63:0] eres,
                           input logic mrw, input logic [4:0] mrd, input logic [63:0] mres);
        bus.exmem_reg_write = erw;
        bus.exmem_rd        = erd;
        bus.exmem_result    = eres;
        bus.memwb_reg_write = mrw;
        bus.memwb_rd        = mrd;
        bus.memwb_result    = mres;
    endtask

    // Queue an expectation, then let the monitor consume it before moving on.
    task automatic push_exp(input string nm, input logic care, input logic v,
                            input logic [63:0] d1, input logic [63:0] d2, input logic [3:0] c,
                            input logic [63:0] st, input logic [4:0] rd, input logic [4:0] c5,
                            input logic lu);
        exp_t e;
        e = '{care: care, v: v, d1: d1, d2: d2, c: c, st: st, rd: rd, c5: c5, lu: lu};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_id(1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 5'($urandom), 5'($urandom), 5'($urandom), 1, 2'b10, 3'b000, 1, 5'b11111);

        // Reset held for two edges
        tick;
        push_exp("reset0", 1, 0, 0, 0, 4'b0000, 0, 0, 5'b00000, 0);
        tick;
        push_exp("reset1", 1, 0, 0, 0, 4'b0000, 0, 0, 5'b00000, 0);
        reset = 1'b0;

        // R-type sub
        drive_id(1, 64'd5, 64'd3, 64'd0, 5'd1, 5'd2, 5'd3, 0, 2'b10, 3'b000, 1, 5'b10000);
        tick;
        push_exp("rsub", 1, 1, 64'd5, 64'd3, 4'b0110, 64'd3, 5'd3, 5'b10000, 0);

        // ALU control decode table
        for (int i = 0; i < 9; i++) begin
            drive_id(1, 64'h100 + 64'(i), 64'h200 + 64'(i), 64'd0, 5'd1, 5'd2, 5'd6, 0,
                     t_op[i], t_f3[i], t_f7[i], 5'b10000);
            tick;
            push_exp($sformatf("decode%0d", i), 1, 1, 64'h100 + 64'(i), 64'h200 + 64'(i),
                     t_exp[i], 64'h200 + 64'(i), 5'd6, 5'b10000, 0);
        end

        // Immediate operand
        drive_id(1, 64'h40, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 5'd2, 5'd7, 1,
                 2'b11, 3'b000, 0, 5'b10000);
        tick;
        push_exp("imm", 1, 1, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0010, 64'h1234, 5'd7, 5'b10000, 0);

        // Forwarding priority (EX rs1=x7, rs2=x9)
        drive_id(1, 64'h11, 64'h22, 64'd0, 5'd7, 5'd9, 5'd8, 0, 2'b00, 3'b000, 0, 5'b10000);
        tick;
        push_exp("fwd_none", 1, 1, 64'h11, 64'h22, 4'b0010, 64'h22, 5'd8, 5'b10000, 0);
        set_fwd(1, 5'd7, 64'hAA, 1, 5'd7, 64'hBB);
        push_exp("fwd_exmem", 1, 1, FWD ? 64'hAA : 64'h11, 64'h22, 4'b0010, 64'h22, 5'd8, 5'b10000, 0);
        set_fwd(0, 5'd7, 64'hAA, 1, 5'd7, 64'hBB);
        push_exp("fwd_memwb", 1, 1, FWD ? 64'hBB : 64'h11, 64'h22, 4'b0010, 64'h22, 5'd8, 5'b10000, 0);
        set_fwd(1, 5'd0, 64'hAA, 1, 5'd0, 64'hBB);
        push_exp("fwd_rd_x0", 1, 1, 64'h11, 64'h22, 4'b0010, 64'h22, 5'd8, 5'b10000, 0);
        set_fwd(1, 5'd7, 64'hAA, 1, 5'd9, 64'hCC);
        push_exp("fwd_split", 1, 1, FWD ? 64'hAA : 64'h11, FWD ? 64'hCC : 64'h22, 4'b0010,
                 FWD ? 64'hCC : 64'h22, 5'd8, 5'b10000, 0);
        set_fwd(0, 0, 0, 0, 0, 0);

        // Source register x0 is never forwarded
        drive_id(1, 64'h55, 64'h66, 64'd0, 5'd0, 5'd0, 5'd8, 0, 2'b00, 3'b000, 0, 5'b10000);
        tick;
        set_fwd(1, 5'd0, 64'hAA, 1, 5'd0, 64'hBB);
        push_exp("fwd_src_x0", 1, 1, 64'h55, 64'h66, 4'b0010, 64'h66, 5'd8, 5'b10000, 0);
        set_fwd(0, 0, 0, 0, 0, 0);

        // Load-use: ld x4, 8(x2)
        drive_id(1, 64'h100, 64'd0, 64'd8, 5'd2, 5'd0, 5'd4, 1, 2'b00, 3'b011, 0, 5'b11010);
        tick;
        push_exp("ld_nohaz", 1, 1, 64'h100, 64'd8, 4'b0010, 64'd0, 5'd4, 5'b11010, 0);
        bus.id_rs2 = 5'd4;
        push_exp("ld_use_rs2", 1, 1, 64'h100, 64'd8, 4'b0010, 64'd0, 5'd4, 5'b11010, 1);
        bus.id_rs2 = 5'd0;
        bus.id_rs1 = 5'd4;
        push_exp("ld_use_rs1", 1, 1, 64'h100, 64'd8, 4'b0010, 64'd0, 5'd4, 5'b11010, 1);
        drive_id(1, 64'h100, 64'd0, 64'd8, 5'd0, 5'd0, 5'd0, 1, 2'b00, 3'b011, 0, 5'b11010);
        tick;
        push_exp("ld_rd_x0", 1, 1, 64'h100, 64'd8, 4'b0010, 64'd0, 5'd0, 5'b11010, 0);
        drive_id(1, 64'd1, 64'd2, 64'd0, 5'd4, 5'd4, 5'd4, 0, 2'b00, 3'b011, 0, 5'b00100);
        tick;
        push_exp("store_no_lu", 1, 1, 64'd1, 64'd2, 4'b0010, 64'd2, 5'd4, 5'b00100, 0);

        // Stall holds for three cycles, then flush+stall makes a bubble
        drive_id(1, 64'h77, 64'h66, 64'd0, 5'd10, 5'd11, 5'd5, 0, 2'b10, 3'b110, 0, 5'b10000);
        tick;
        push_exp("stall_load", 1, 1, 64'h77, 64'h66, 4'b0001, 64'h66, 5'd5, 5'b10000, 0);
        bus.stall = 1'b1;
        drive_id(1, 64'h33, 64'h44, 64'd0, 5'd12, 5'd13, 5'd6, 0, 2'b10, 3'b111, 0, 5'b10000);
        for (int i = 0; i < 3; i++) begin
            tick;
            push_exp($sformatf("stall_hold%0d", i), 1, 1, 64'h77, 64'h66, 4'b0001, 64'h66,
                     5'd5, 5'b10000, 0);
        end
        bus.flush = 1'b1;
        tick;
        push_exp("flush_stall", 0, 0, 0, 0, 4'b0000, 0, 0, 5'b00000, 0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        tick;
        push_exp("after_flush", 1, 1, 64'h33, 64'h44, 4'b0000, 64'h44, 5'd6, 5'b10000, 0);

        // Reset during stall clears on that edge
        bus.stall = 1'b1;
        reset     = 1'b1;
        tick;
        push_exp("reset_stall", 1, 0, 0, 0, 4'b0000, 0, 0, 5'b00000, 0);
        reset     = 1'b0;
        bus.stall = 1'b0;

        // Invalid ID instruction with control bits set
        drive_id(0, 64'd9, 64'd8, 64'd0, 5'd1, 5'd2, 5'd3, 0, 2'b10, 3'b000, 1, 5'b11111);
        tick;
        push_exp("id_invalid", 0, 0, 0, 0, 4'b0000, 0, 0, 5'b00000, 0);

        // Branch then flush alone
        drive_id(1, 64'd5, 64'd6, 64'd0, 5'd1, 5'd2, 5'd3, 0, 2'b01, 3'b000, 0, 5'b00001);
        tick;
        push_exp("branch", 1, 1, 64'd5, 64'd6, 4'b0110, 64'd6, 5'd3, 5'b00001, 0);
        bus.flush = 1'b1;
        tick;
        push_exp("flush", 0, 0, 0, 0, 4'b0000, 0, 0, 5'b00000, 0);
        bus.flush = 1'b0;

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
